// File: rtl/blocked_path_mapper.sv
// Snapshots the receiver's blocked-path vector on done rise and streams one
// edge record per blocked bit, lowest bit first, over a valid/ready handshake.
module blocked_path_mapper #(
    parameter int unsigned NODE_W = 4,
    parameter logic [2*NODE_W*16-1:0] EDGE_MAP = 128'hF0EF_DECD_BCAB_9A89_7867_5645_3423_1201
) (
    input  logic              samp_clock_i,
    input  logic              rst_n_i,
    input  logic [15:0]       blocked_path_i,
    input  logic              rx_data_done_i,
    output logic              edge_valid_o,
    input  logic              edge_ready_i,
    output logic [3:0]        edge_id_o,
    output logic [NODE_W-1:0] edge_node_a_o,
    output logic [NODE_W-1:0] edge_node_b_o,
    output logic              edge_last_o,
    output logic [4:0]        block_count_o,
    output logic              busy_o,
    output logic              map_done_o
);

    localparam int unsigned NUM_EDGES = 16;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned REC_W     = 2 * NODE_W;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;

    state_e                 state_q, state_d;
    logic                   done_q;
    logic [NUM_EDGES-1:0]   snap_q, snap_d;
    logic [ID_W-1:0]        idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [NODE_W-1:0]      node_a_q, node_a_d;
    logic [NODE_W-1:0]      node_b_q, node_b_d;
    logic                   last_q, last_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   busy_q, busy_d;
    logic                   map_done_q, map_done_d;

    logic                   rise;
    logic [REC_W-1:0]       map_rec;
    logic [CNT_W-1:0]       shamt;
    logic                   at_top;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        id_d       = id_q;
        node_a_d   = node_a_q;
        node_b_d   = node_b_q;
        last_d     = last_q;
        count_d    = count_q;
        map_done_d = map_done_q;

        rise    = rx_data_done_i & ~done_q;
        map_rec = EDGE_MAP[idx_q*REC_W +: REC_W];
        shamt   = CNT_W'(idx_q) + CNT_W'(1);
        at_top  = (idx_q == ID_W'(NUM_EDGES - 1));

        case (state_q)
            IDLE: begin
                if (rise) begin
                    snap_d  = blocked_path_i;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (snap_q[idx_q]) begin
                    id_d     = idx_q;
                    node_a_d = map_rec[REC_W-1 -: NODE_W];
                    node_b_d = map_rec[NODE_W-1:0];
                    last_d   = ~|(snap_q >> shamt);
                    valid_d  = 1'b1;
                    state_d  = EMIT;
                end else if (at_top) begin
                    map_done_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + ID_W'(1);
                end
            end
            EMIT: begin
                if (edge_ready_i) begin
                    valid_d = 1'b0;
                    count_d = count_q + CNT_W'(1);
                    if (at_top) begin
                        map_done_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        idx_d   = idx_q + ID_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                if (!rx_data_done_i) begin
                    map_done_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SCAN) || (state_d == EMIT);
    end

    // done_q tracks the input even in reset so a held-high done is not a new rise
    always_ff @(posedge samp_clock_i) begin
        done_q <= rx_data_done_i;
    end

    always_ff @(posedge samp_clock_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            node_a_q   <= '0;
            node_b_q   <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            map_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            node_a_q   <= node_a_d;
            node_b_q   <= node_b_d;
            last_q     <= last_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            map_done_q <= map_done_d;
        end
    end

    assign edge_valid_o  = valid_q;
    assign edge_id_o     = id_q;
    assign edge_node_a_o = node_a_q;
    assign edge_node_b_o = node_b_q;
    assign edge_last_o   = last_q;
    assign block_count_o = count_q;
    assign busy_o        = busy_q;
    assign map_done_o    = map_done_q;

endmodule

// File: tb/tb_blocked_path_mapper.sv
// Scoreboard bench for blocked_path_mapper: expected records are queued when a
// session is launched and compared on every cycle the DUT presents a record.
module tb_blocked_path_mapper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [15:0] blocked_path;
    logic       rx_done;
    logic       edge_valid;
    logic       edge_ready;
    logic [3:0] edge_id;
    logic [3:0] node_a;
    logic [3:0] node_b;
    logic       edge_last;
    logic [4:0] block_count;
    logic       busy;
    logic       map_done;

    typedef struct packed {
        logic [3:0] id;
        logic [3:0] a;
        logic [3:0] b;
        logic       last;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    blocked_path_mapper dut (
        .samp_clock_i   (clk),
        .rst_n_i        (rst_n),
        .blocked_path_i (blocked_path),
        .rx_data_done_i (rx_done),
        .edge_valid_o   (edge_valid),
        .edge_ready_i   (edge_ready),
        .edge_id_o      (edge_id),
        .edge_node_a_o  (node_a),
        .edge_node_b_o  (node_b),
        .edge_last_o    (edge_last),
        .block_count_o  (block_count),
        .busy_o         (busy),
        .map_done_o     (map_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default ring map: edge i joins node i to node (i+1)%16
    task automatic push_exp(input logic [15:0] v);
        rec_t r;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                r.id   = 4'(i);
                r.a    = 4'(i);
                r.b    = 4'((i + 1) % 16);
                r.last = ((v >> (i + 1)) == 16'h0);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic wait_map_done(input string tag, output int n);
        n = 0;
        while (!map_done && n < 300) begin
            tick();
            n++;
        end
        if (!map_done) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic end_session(input string tag, input int exp_cnt);
        check_eq({tag, "_count"}, 32'(block_count), 32'(exp_cnt));
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        rx_done = 1'b0;
        tick();
        check_eq({tag, "_done_clear"}, 32'(map_done), 32'd0);
        tick();
    endtask

    // Every presented record must match the head of the scoreboard
    always @(negedge clk) begin
        rec_t e;
        if (edge_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_record", {28'd0, edge_id}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q[0];
                check_eq("rec_id",   32'(edge_id),   32'(e.id));
                check_eq("rec_a",    32'(node_a),    32'(e.a));
                check_eq("rec_b",    32'(node_b),    32'(e.b));
                check_eq("rec_last", 32'(edge_last), 32'(e.last));
                if (edge_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        blocked_path = 16'h0;
        rx_done      = 1'b0;
        edge_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_valid", 32'(edge_valid), 32'd0);
        check_eq("rst_busy",  32'(busy),       32'd0);
        check_eq("rst_done",  32'(map_done),   32'd0);
        check_eq("rst_count", 32'(block_count), 32'd0);
        check_eq("rst_rec",   {19'd0, edge_id, node_a, node_b, edge_last}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single record, bit 5
        blocked_path = 16'h0020;
        edge_ready   = 1'b1;
        push_exp(16'h0020);
        rx_done = 1'b1;
        wait_map_done("t2", n);
        check_eq("t2_latency", 32'(n), 32'd18);
        end_session("t2", 1);

        // Two records, first held under backpressure
        blocked_path = 16'h8002;
        edge_ready   = 1'b0;
        push_exp(16'h8002);
        rx_done = 1'b1;
        n = 0;
        while (!edge_valid && n < 50) begin tick(); n++; end
        check_eq("t3_first_valid", 32'(edge_valid), 32'd1);
        tick();
        tick();
        check_eq("t3_held_id", 32'(edge_id), 32'd1);
        check_eq("t3_count_held", 32'(block_count), 32'd0);
        edge_ready = 1'b1;
        wait_map_done("t3", n);
        end_session("t3", 2);

        // Empty vector: no records, done 16 edges after the rise edge
        blocked_path = 16'h0000;
        rx_done = 1'b1;
        wait_map_done("t4", n);
        check_eq("t4_latency", 32'(n), 32'd17);
        end_session("t4", 0);

        // Full vector: 16 records, count saturates at 16
        blocked_path = 16'hFFFF;
        push_exp(16'hFFFF);
        rx_done = 1'b1;
        wait_map_done("t5", n);
        check_eq("t5_latency", 32'(n), 32'd33);
        end_session("t5", 16);

        // Reset during EMIT aborts; held-high done must not restart
        blocked_path = 16'h0101;
        edge_ready   = 1'b0;
        push_exp(16'h0101);
        rx_done = 1'b1;
        n = 0;
        while (!edge_valid && n < 50) begin tick(); n++; end
        check_eq("t6_valid_latency", 32'(n), 32'd2);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check_eq("t6_rst_valid", 32'(edge_valid), 32'd0);
        check_eq("t6_rst_busy",  32'(busy),       32'd0);
        rst_n      = 1'b1;
        edge_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_eq("t6_no_restart_busy", 32'(busy),     32'd0);
        check_eq("t6_no_restart_done", 32'(map_done), 32'd0);
        rx_done = 1'b0;
        tick();
        push_exp(16'h0101);
        rx_done = 1'b1;
        tick();
        tick();
        blocked_path = 16'h0010;
        wait_map_done("t6", n);
        end_session("t6", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
